// File: rtl/feeder_dispatcher.sv
// Host-side dispatcher for the branch feeder tree: issues tasks, sinks results,
// caps in-flight work, keeps issue/retire statistics and supports drain.
module feeder_dispatcher #(
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter int unsigned CNT_W           = 32
) (
  input  logic               clock,
  input  logic               reset,

  input  logic [143:0]       task_data,
  input  logic               task_valid,
  output logic               task_ready,

  output logic [143:0]       feed_data,
  output logic               feed_valid,
  input  logic               feed_ready,

  input  logic [39:0]        result_data,
  input  logic               result_valid,
  output logic               result_ready,

  output logic [39:0]        out_data,
  output logic               out_valid,
  input  logic               out_ready,

  input  logic               drain,
  output logic               drained,
  output logic [7:0]         outstanding,
  output logic [CNT_W-1:0]   issued_count,
  output logic [CNT_W-1:0]   retired_count,
  output logic               err_underflow
);

  localparam int unsigned TASK_W = 144;
  localparam int unsigned RES_W  = 40;
  localparam int unsigned OUT_W  = 8;
  localparam logic [OUT_W-1:0] CAP = OUT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAINING = 2'd1,
    ST_DRAINED  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               drained_q, drained_d;

  logic [TASK_W-1:0]  feed_data_q, feed_data_d;
  logic               feed_valid_q, feed_valid_d;
  logic [RES_W-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;

  logic [OUT_W-1:0]   outstanding_q, outstanding_d;
  logic [CNT_W-1:0]   issued_q, issued_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               err_q, err_d;

  logic               feed_load_c;
  logic               task_ready_c;
  logic               result_ready_c;
  logic               task_acc_c;
  logic               res_acc_c;
  logic               idle_c;

  // Handshake qualifiers; readies never look at their own interface's valid.
  always_comb begin
    feed_load_c    = !feed_valid_q || feed_ready;
    task_ready_c   = (state_q == ST_RUN) && feed_load_c && (outstanding_q < CAP);
    result_ready_c = !out_valid_q || out_ready;
    task_acc_c     = task_valid && task_ready_c;
    res_acc_c      = result_valid && result_ready_c;
    idle_c         = (outstanding_q == '0) && !feed_valid_q && !out_valid_q;
  end

  // Task pipeline register toward the feeder tree.
  always_comb begin
    feed_valid_d = feed_valid_q;
    feed_data_d  = feed_data_q;
    if (task_acc_c) begin
      feed_valid_d = 1'b1;
      feed_data_d  = task_data;
    end else if (feed_ready) begin
      feed_valid_d = 1'b0;
    end
  end

  // Result pipeline register toward the host.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (res_acc_c) begin
      out_valid_d = 1'b1;
      out_data_d  = result_data;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // In-flight tracking; a stray result pins the count at zero and flags an error.
  always_comb begin
    outstanding_d = outstanding_q;
    err_d         = err_q;
    if (task_acc_c && !res_acc_c) begin
      outstanding_d = outstanding_q + OUT_W'(1);
    end else if (!task_acc_c && res_acc_c) begin
      if (outstanding_q == '0) begin
        err_d = 1'b1;
      end else begin
        outstanding_d = outstanding_q - OUT_W'(1);
      end
    end
  end

  always_comb begin
    issued_d  = issued_q;
    retired_d = retired_q;
    if (task_acc_c) begin
      issued_d = issued_q + CNT_W'(1);
    end
    if (res_acc_c) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  // Drain control: releasing drain always returns to RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (drain) begin
          state_d = ST_DRAINING;
        end
      end
      ST_DRAINING: begin
        if (!drain) begin
          state_d = ST_RUN;
        end else if (idle_c) begin
          state_d = ST_DRAINED;
        end
      end
      ST_DRAINED: begin
        if (!drain) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
    drained_d = (state_d == ST_DRAINED);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      drained_q     <= 1'b0;
      feed_data_q   <= '0;
      feed_valid_q  <= 1'b0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      outstanding_q <= '0;
      issued_q      <= '0;
      retired_q     <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      drained_q     <= drained_d;
      feed_data_q   <= feed_data_d;
      feed_valid_q  <= feed_valid_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      outstanding_q <= outstanding_d;
      issued_q      <= issued_d;
      retired_q     <= retired_d;
      err_q         <= err_d;
    end
  end

  assign task_ready    = task_ready_c;
  assign result_ready  = result_ready_c;
  assign feed_data     = feed_data_q;
  assign feed_valid    = feed_valid_q;
  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign drained       = drained_q;
  assign outstanding   = outstanding_q;
  assign issued_count  = issued_q;
  assign retired_count = retired_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_feeder_dispatcher.sv
// Bench for feeder_dispatcher: per-cycle expectation vectors plus a data
// scoreboard for the feed and result streams.
module tb_feeder_dispatcher;

  localparam int unsigned CNT_W = 32;

  logic              clock;
  logic              reset;
  logic [143:0]      task_data;
  logic              task_valid;
  logic              task_ready;
  logic [143:0]      feed_data;
  logic              feed_valid;
  logic              feed_ready;
  logic [39:0]       result_data;
  logic              result_valid;
  logic              result_ready;
  logic [39:0]       out_data;
  logic              out_valid;
  logic              out_ready;
  logic              drain;
  logic              drained;
  logic [7:0]        outstanding;
  logic [CNT_W-1:0]  issued_count;
  logic [CNT_W-1:0]  retired_count;
  logic              err_underflow;

  feeder_dispatcher #(.MAX_OUTSTANDING(4), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .task_data(task_data), .task_valid(task_valid), .task_ready(task_ready),
    .feed_data(feed_data), .feed_valid(feed_valid), .feed_ready(feed_ready),
    .result_data(result_data), .result_valid(result_valid), .result_ready(result_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .drain(drain), .drained(drained), .outstanding(outstanding),
    .issued_count(issued_count), .retired_count(retired_count),
    .err_underflow(err_underflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       tv;
    logic [7:0] td;
    logic       fr;
    logic       rv;
    logic [7:0] rd;
    logic       orr;
    logic       drn;
    logic       e_tr;
    logic       e_rr;
    logic       e_fv;
    logic       e_ov;
    logic [7:0] e_os;
    logic       e_dr;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int step   = 0;
  logic [143:0] feed_q[$];
  logic [39:0]  out_q[$];

  function automatic logic [143:0] mk_task(input logic [7:0] t);
    return {t, {16{t ^ 8'h5A}}, t};
  endfunction

  function automatic logic [39:0] mk_res(input logic [7:0] t);
    return {t, 32'h3456_789A};
  endfunction

  function automatic vec_t V(input logic tv, input logic [7:0] td, input logic fr,
                             input logic rv, input logic [7:0] rd, input logic orr,
                             input logic drn, input logic e_tr, input logic e_rr,
                             input logic e_fv, input logic e_ov, input logic [7:0] e_os,
                             input logic e_dr);
    vec_t v;
    v.tv = tv; v.td = td; v.fr = fr; v.rv = rv; v.rd = rd; v.orr = orr; v.drn = drn;
    v.e_tr = e_tr; v.e_rr = e_rr; v.e_fv = e_fv; v.e_ov = e_ov; v.e_os = e_os; v.e_dr = e_dr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d got=%0h expected=%0h", name, step, act, exp);
    end
  endtask

  // Drive one cycle, check pre-edge outputs, and run the stream scoreboard.
  task automatic cyc(input vec_t v);
    logic [143:0] ef;
    logic [39:0]  eo;
    @(negedge clock);
    task_valid   = v.tv;
    task_data    = v.tv ? mk_task(v.td) : '0;
    feed_ready   = v.fr;
    result_valid = v.rv;
    result_data  = v.rv ? mk_res(v.rd) : '0;
    out_ready    = v.orr;
    drain        = v.drn;
    #1;
    step++;
    chk("task_ready",   144'(task_ready),   144'(v.e_tr));
    chk("result_ready", 144'(result_ready), 144'(v.e_rr));
    chk("feed_valid",   144'(feed_valid),   144'(v.e_fv));
    chk("out_valid",    144'(out_valid),    144'(v.e_ov));
    chk("outstanding",  144'(outstanding),  144'(v.e_os));
    chk("drained",      144'(drained),      144'(v.e_dr));
    if (feed_valid && feed_ready) begin
      if (feed_q.size() == 0) begin
        chk("feed_extra", 144'(feed_valid), 144'(0));
      end else begin
        ef = feed_q.pop_front();
        chk("feed_data", feed_data, ef);
      end
    end
    if (out_valid && out_ready) begin
      if (out_q.size() == 0) begin
        chk("out_extra", 144'(out_valid), 144'(0));
      end else begin
        eo = out_q.pop_front();
        chk("out_data", 144'(out_data), 144'(eo));
      end
    end
    if (v.tv && v.e_tr) feed_q.push_back(mk_task(v.td));
    if (v.rv && v.e_rr) out_q.push_back(mk_res(v.rd));
  endtask

  vec_t tbl[8];

  initial begin
    clock = 1'b0;
    reset = 1'b0;
    task_valid = 1'b0; task_data = '0; feed_ready = 1'b0;
    result_valid = 1'b0; result_data = '0; out_ready = 1'b0; drain = 1'b0;

    // Single task, result returned five cycles after acceptance.
    tbl[0] = V(1, 8'h0A, 1, 0, 8'h00, 1, 0, 1, 1, 0, 0, 8'd0, 0);
    tbl[1] = V(0, 8'h00, 1, 0, 8'h00, 1, 0, 1, 1, 1, 0, 8'd1, 0);
    tbl[2] = V(0, 8'h00, 1, 0, 8'h00, 1, 0, 1, 1, 0, 0, 8'd1, 0);
    tbl[3] = V(0, 8'h00, 1, 0, 8'h00, 1, 0, 1, 1, 0, 0, 8'd1, 0);
    tbl[4] = V(0, 8'h00, 1, 0, 8'h00, 1, 0, 1, 1, 0, 0, 8'd1, 0);
    tbl[5] = V(0, 8'h00, 1, 1, 8'h12, 1, 0, 1, 1, 0, 0, 8'd1, 0);
    tbl[6] = V(0, 8'h00, 1, 0, 8'h00, 1, 0, 1, 1, 0, 1, 8'd0, 0);
    tbl[7] = V(0, 8'h00, 1, 0, 8'h00, 1, 0, 1, 1, 0, 0, 8'd0, 0);

    repeat (2) @(posedge clock);
    #1;
    chk("rst_feed_valid", 144'(feed_valid), 144'(0));
    chk("rst_out_valid",  144'(out_valid), 144'(0));
    chk("rst_outstanding", 144'(outstanding), 144'(0));
    chk("rst_issued", 144'(issued_count), 144'(0));
    chk("rst_retired", 144'(retired_count), 144'(0));
    chk("rst_err", 144'(err_underflow), 144'(0));
    chk("rst_drained", 144'(drained), 144'(0));
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) cyc(tbl[i]);
    chk("issued_a", 144'(issued_count), 144'(1));
    chk("retired_a", 144'(retired_count), 144'(1));
    chk("result_a", 144'(out_data), 144'(40'h12_3456_789A));

    // Cap of 4 with task_valid held, then one result frees a slot.
    cyc(V(1, 8'h21, 1, 0, 8'h00, 1, 0, 1, 1, 0, 0, 8'd0, 0));
    cyc(V(1, 8'h22, 1, 0, 8'h00, 1, 0, 1, 1, 1, 0, 8'd1, 0));
    cyc(V(1, 8'h23, 1, 0, 8'h00, 1, 0, 1, 1, 1, 0, 8'd2, 0));
    cyc(V(1, 8'h24, 1, 0, 8'h00, 1, 0, 1, 1, 1, 0, 8'd3, 0));
    cyc(V(1, 8'h25, 1, 0, 8'h00, 1, 0, 0, 1, 1, 0, 8'd4, 0));
    cyc(V(1, 8'h25, 1, 0, 8'h00, 1, 0, 0, 1, 0, 0, 8'd4, 0));
    cyc(V(1, 8'h25, 1, 1, 8'h31, 1, 0, 0, 1, 0, 0, 8'd4, 0));
    cyc(V(1, 8'h25, 1, 0, 8'h00, 1, 0, 1, 1, 0, 1, 8'd3, 0));
    cyc(V(0, 8'h00, 1, 0, 8'h00, 1, 0, 0, 1, 1, 0, 8'd4, 0));
    cyc(V(0, 8'h00, 1, 0, 8'h00, 1, 0, 0, 1, 0, 0, 8'd4, 0));
    cyc(V(0, 8'h00, 1, 1, 8'h32, 1, 0, 0, 1, 0, 0, 8'd4, 0));
    cyc(V(0, 8'h00, 1, 1, 8'h33, 1, 0, 1, 1, 0, 1, 8'd3, 0));
    cyc(V(0, 8'h00, 1, 1, 8'h34, 1, 0, 1, 1, 0, 1, 8'd2, 0));
    cyc(V(0, 8'h00, 1, 1, 8'h35, 1, 0, 1, 1, 0, 1, 8'd1, 0));
    cyc(V(0, 8'h00, 1, 0, 8'h00, 1, 0, 1, 1, 0, 1, 8'd0, 0));
    cyc(V(0, 8'h00, 1, 0, 8'h00, 1, 0, 1, 1, 0, 0, 8'd0, 0));

    // Feed backpressure: one task held stable, the next two issue back to back.
    cyc(V(1, 8'h01, 0, 0, 8'h00, 1, 0, 1, 1, 0, 0, 8'd0, 0));
    for (int i = 0; i < 9; i++) begin
      cyc(V(1, 8'h02, 0, 0, 8'h00, 1, 0, 0, 1, 1, 0, 8'd1, 0));
      chk("feed_hold", feed_data, mk_task(8'h01));
    end
    cyc(V(1, 8'h02, 1, 0, 8'h00, 1, 0, 1, 1, 1, 0, 8'd1, 0));
    cyc(V(1, 8'h03, 1, 0, 8'h00, 1, 0, 1, 1, 1, 0, 8'd2, 0));
    cyc(V(0, 8'h00, 1, 0, 8'h00, 1, 0, 1, 1, 1, 0, 8'd3, 0));

    // Simultaneous task and result accept at outstanding == 2.
    cyc(V(0, 8'h00, 1, 1, 8'h41, 1, 0, 1, 1, 0, 0, 8'd3, 0));
    cyc(V(1, 8'h04, 1, 1, 8'h42, 1, 0, 1, 1, 0, 1, 8'd2, 0));
    chk("issued_pre", 144'(issued_count), 144'(9));
    chk("retired_pre", 144'(retired_count), 144'(7));
    cyc(V(0, 8'h00, 1, 0, 8'h00, 1, 0, 1, 1, 1, 1, 8'd2, 0));
    chk("issued_sim", 144'(issued_count), 144'(10));
    chk("retired_sim", 144'(retired_count), 144'(8));
    cyc(V(0, 8'h00, 1, 0, 8'h00, 1, 0, 1, 1, 0, 0, 8'd2, 0));

    // Drain: accept coinciding with drain completes, held task still issues.
    cyc(V(1, 8'h05, 1, 0, 8'h00, 1, 0, 1, 1, 0, 0, 8'd2, 0));
    cyc(V(1, 8'h06, 1, 0, 8'h00, 1, 1, 1, 1, 1, 0, 8'd3, 0));
    cyc(V(1, 8'h07, 1, 0, 8'h00, 1, 1, 0, 1, 1, 0, 8'd4, 0));
    cyc(V(0, 8'h00, 1, 1, 8'h51, 1, 1, 0, 1, 0, 0, 8'd4, 0));
    cyc(V(0, 8'h00, 1, 1, 8'h52, 1, 1, 0, 1, 0, 1, 8'd3, 0));
    cyc(V(0, 8'h00, 1, 1, 8'h53, 1, 1, 0, 1, 0, 1, 8'd2, 0));
    cyc(V(0, 8'h00, 1, 1, 8'h54, 1, 1, 0, 1, 0, 1, 8'd1, 0));
    cyc(V(0, 8'h00, 1, 0, 8'h00, 1, 1, 0, 1, 0, 1, 8'd0, 0));
    cyc(V(0, 8'h00, 1, 0, 8'h00, 1, 1, 0, 1, 0, 0, 8'd0, 0));
    cyc(V(0, 8'h00, 1, 0, 8'h00, 1, 1, 0, 1, 0, 0, 8'd0, 1));
    cyc(V(0, 8'h00, 1, 0, 8'h00, 1, 0, 0, 1, 0, 0, 8'd0, 1));
    cyc(V(1, 8'h08, 1, 0, 8'h00, 1, 0, 1, 1, 0, 0, 8'd0, 0));
    cyc(V(0, 8'h00, 1, 0, 8'h00, 1, 0, 1, 1, 1, 0, 8'd1, 0));

    // Output backpressure, then a stray result triggers underflow.
    cyc(V(0, 8'h00, 1, 1, 8'h61, 1, 0, 1, 1, 0, 0, 8'd1, 0));
    cyc(V(0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 0, 0, 1, 8'd0, 0));
    cyc(V(0, 8'h00, 1, 0, 8'h00, 1, 0, 1, 1, 0, 1, 8'd0, 0));
    cyc(V(0, 8'h00, 1, 0, 8'h00, 1, 0, 1, 1, 0, 0, 8'd0, 0));
    chk("err_clear", 144'(err_underflow), 144'(0));
    cyc(V(0, 8'h00, 1, 1, 8'h62, 1, 0, 1, 1, 0, 0, 8'd0, 0));
    cyc(V(0, 8'h00, 1, 0, 8'h00, 1, 0, 1, 1, 0, 1, 8'd0, 0));
    chk("err_set", 144'(err_underflow), 144'(1));
    chk("issued_uf", 144'(issued_count), 144'(13));
    chk("retired_uf", 144'(retired_count), 144'(14));
    chk("feed_q_empty", 144'(feed_q.size()), 144'(0));
    chk("out_q_empty", 144'(out_q.size()), 144'(0));

    // Asynchronous reset in the middle of a cycle with a task in flight.
    cyc(V(1, 8'h09, 0, 0, 8'h00, 1, 0, 1, 1, 0, 0, 8'd0, 0));
    @(posedge clock);
    #1;
    chk("pre_rst_fv", 144'(feed_valid), 144'(1));
    #2;
    reset = 1'b0;
    #1;
    chk("arst_feed_valid", 144'(feed_valid), 144'(0));
    chk("arst_feed_data", feed_data, 144'(0));
    chk("arst_out_data", 144'(out_data), 144'(0));
    chk("arst_outstanding", 144'(outstanding), 144'(0));
    chk("arst_issued", 144'(issued_count), 144'(0));
    chk("arst_retired", 144'(retired_count), 144'(0));
    chk("arst_err", 144'(err_underflow), 144'(0));
    feed_q.delete();
    out_q.delete();
    task_valid = 1'b0; feed_ready = 1'b0; result_valid = 1'b0; out_ready = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    cyc(V(0, 8'h00, 1, 0, 8'h00, 1, 0, 1, 1, 0, 0, 8'd0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
